// File: rtl/pipeline_hazard_ctrl_if.sv
// pipeline_hazard_ctrl_if: pipeline status into, and stage-register control out of, the hazard controller
//   master: pipeline side; drives hit/hazard status and receives wen/flush/stall_count
//   slave : controller side; receives status and drives wen/flush/stall_count
interface pipeline_hazard_ctrl_if #(
   parameter int STALL_CNT_W = 16
);
   logic                   ihit;
   logic                   dhit;
   logic                   ex_memread;
   logic [4:0]             ex_rt;
   logic [4:0]             id_rs;
   logic [4:0]             id_rt;
   logic                   mem_memread;
   logic                   mem_memwrite;
   logic                   mem_branch_taken;
   logic                   halt;
   logic                   pc_wen;
   logic                   ifid_wen;
   logic                   idex_wen;
   logic                   exmem_wen;
   logic                   memwb_wen;
   logic                   ifid_flush;
   logic                   idex_flush;
   logic                   exmem_flush;
   logic [STALL_CNT_W-1:0] stall_count;
   modport master (
      output ihit, dhit, ex_memread, ex_rt, id_rs, id_rt, mem_memread, mem_memwrite,
             mem_branch_taken, halt,
      input  pc_wen, ifid_wen, idex_wen, exmem_wen, memwb_wen,
             ifid_flush, idex_flush, exmem_flush, stall_count
   );
   modport slave (
      input  ihit, dhit, ex_memread, ex_rt, id_rs, id_rt, mem_memread, mem_memwrite,
             mem_branch_taken, halt,
      output pc_wen, ifid_wen, idex_wen, exmem_wen, memwb_wen,
             ifid_flush, idex_flush, exmem_flush, stall_count
   );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl: 5-stage pipeline stall/flush controller with stall-cycle counter
//   CLK  : clock, all state on rising edge
//   nRST : asynchronous active-low reset
//   bus  : status inputs (hits, load-use operands, mem ops, branch, halt) and
//          stage-register wen/flush outputs plus saturating stall_count
module pipeline_hazard_ctrl #(
   parameter int STALL_CNT_W = 16
) (
   input logic                    CLK,
   input logic                    nRST,
   pipeline_hazard_ctrl_if.slave  bus
);
   typedef enum logic [1:0] {RUN, DWAIT, HALTED} state_t;
   state_t                 state;
   logic                   lu;
   logic                   mb;
   logic [7:0]             ctl;
   logic [STALL_CNT_W-1:0] stall_count;
   assign lu = bus.ex_memread && bus.ex_rt != 5'd0 && (bus.ex_rt == bus.id_rs || bus.ex_rt == bus.id_rt);
   assign mb = (bus.mem_memread || bus.mem_memwrite) && !bus.dhit;
   // ctl = {pc, ifid, idex, exmem, memwb wen, ifid, idex, exmem flush}; reset forces everything low
   // A taken branch outranks load-use because its flush kills the dependent instruction anyway.
   assign ctl = (!nRST || state == HALTED || mb) ? 8'b00000_000 :
                bus.mem_branch_taken             ? 8'b11111_111 :
                lu                               ? 8'b00111_010 :
                !bus.ihit                        ? 8'b01111_100 :
                                                   8'b11111_000;
   assign {bus.pc_wen, bus.ifid_wen, bus.idex_wen, bus.exmem_wen, bus.memwb_wen,
           bus.ifid_flush, bus.idex_flush, bus.exmem_flush} = ctl;
   assign bus.stall_count = stall_count;
   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         state       <= RUN;
         stall_count <= '0;
      end else begin
         state <= (state == HALTED || bus.halt) ? HALTED : mb ? DWAIT : RUN;
         if (!ctl[7] && state != HALTED && stall_count != '1)
            stall_count <= stall_count + 1'b1;
      end
   end
endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// tb_pipeline_hazard_ctrl: directed vectors with a queued scoreboard checked by an independent monitor
module tb_pipeline_hazard_ctrl;
   localparam logic [7:0] NRM = 8'b11111_000;
   localparam logic [7:0] LDU = 8'b00111_010;
   localparam logic [7:0] IHM = 8'b01111_100;
   localparam logic [7:0] BRT = 8'b11111_111;
   localparam logic [7:0] ZER = 8'b00000_000;
   typedef struct {
      string      nm;
      logic [7:0] ctl;
      int         cnt;
   } exp_t;
   logic CLK = 1'b0;
   logic nRST = 1'b0;
   exp_t q[$];
   int   tests = 0;
   int   fails = 0;
   bit   done = 1'b0;
   pipeline_hazard_ctrl_if #(.STALL_CNT_W(4)) bus ();
   pipeline_hazard_ctrl #(.STALL_CNT_W(4)) dut (.CLK(CLK), .nRST(nRST), .bus(bus));
   always #5 CLK = ~CLK;
   task automatic drive(input string nm, input logic rn, input logic ihit, input logic dhit,
                        input logic exmr, input logic [4:0] ex_rt, input logic [4:0] id_rs,
                        input logic [4:0] id_rt, input logic mmr, input logic mmw,
                        input logic br, input logic hl, input logic [7:0] ectl, input int ecnt);
      exp_t e;
      @(negedge CLK);
      nRST                 = rn;
      bus.ihit             = ihit;
      bus.dhit             = dhit;
      bus.ex_memread       = exmr;
      bus.ex_rt            = ex_rt;
      bus.id_rs            = id_rs;
      bus.id_rt            = id_rt;
      bus.mem_memread      = mmr;
      bus.mem_memwrite     = mmw;
      bus.mem_branch_taken = br;
      bus.halt             = hl;
      e.nm  = nm;
      e.ctl = ectl;
      e.cnt = ecnt;
      q.push_back(e);
   endtask
   task automatic norm(input string nm, input logic [7:0] ectl, input int ecnt);
      drive(nm, 1'b1, 1'b1, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, ectl, ecnt);
   endtask
   // monitor: samples mid-low-phase, after the driver has applied this cycle's vector
   initial begin
      exp_t      e;
      logic [7:0] act;
      forever begin
         @(negedge CLK);
         #2;
         if (q.size() != 0) begin
            e   = q.pop_front();
            act = {bus.pc_wen, bus.ifid_wen, bus.idex_wen, bus.exmem_wen, bus.memwb_wen,
                   bus.ifid_flush, bus.idex_flush, bus.exmem_flush};
            tests++;
            if (act !== e.ctl) begin
               fails++;
               $display("FAIL %s ctl: got %b expected %b", e.nm, act, e.ctl);
            end
            tests++;
            if (bus.stall_count !== 4'(e.cnt)) begin
               fails++;
               $display("FAIL %s stall_count: got %0d expected %0d", e.nm, bus.stall_count, e.cnt);
            end
         end
      end
   end
   initial begin
      drive("reset0", 1'b0, 1'b1, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, ZER, 0);
      drive("reset1", 1'b0, 1'b0, 1'b0, 1'b1, 5'd5, 5'd5, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, ZER, 0);
      norm("normal0", NRM, 0);
      drive("lu_rs", 1'b1, 1'b1, 1'b0, 1'b1, 5'd5, 5'd5, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, LDU, 0);
      drive("lu_r0", 1'b1, 1'b1, 1'b0, 1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, NRM, 1);
      drive("lu_rt", 1'b1, 1'b1, 1'b0, 1'b1, 5'd7, 5'd3, 5'd7, 1'b0, 1'b0, 1'b0, 1'b0, LDU, 1);
      drive("lu_nomatch", 1'b1, 1'b1, 1'b0, 1'b1, 5'd7, 5'd3, 5'd4, 1'b0, 1'b0, 1'b0, 1'b0, NRM, 2);
      drive("imiss", 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, IHM, 2);
      drive("br_lu_imiss", 1'b1, 1'b0, 1'b0, 1'b1, 5'd5, 5'd5, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, BRT, 3);
      norm("after_br", NRM, 3);
      drive("dwait0", 1'b1, 1'b1, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, ZER, 3);
      drive("dwait1", 1'b1, 1'b1, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, ZER, 4);
      drive("dwait2", 1'b1, 1'b1, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, ZER, 5);
      drive("dwait_hit", 1'b1, 1'b1, 1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, NRM, 6);
      norm("dwait_run", NRM, 6);
      drive("wr_wait", 1'b1, 1'b1, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, ZER, 6);
      drive("wr_hit_lu", 1'b1, 1'b1, 1'b1, 1'b1, 5'd9, 5'd9, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, LDU, 7);
      norm("after_wr", NRM, 8);
      drive("dwait_pre", 1'b1, 1'b1, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, ZER, 8);
      drive("async_rst", 1'b0, 1'b1, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, ZER, 0);
      norm("rst_release", NRM, 0);
      drive("halt_in", 1'b1, 1'b1, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, NRM, 0);
      norm("halted0", ZER, 0);
      drive("halted_imiss", 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, ZER, 0);
      drive("halted_mb", 1'b1, 1'b1, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, ZER, 0);
      drive("halted_br", 1'b1, 1'b1, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, ZER, 0);
      drive("halt_rst", 1'b0, 1'b1, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, ZER, 0);
      norm("halt_recover", NRM, 0);
      for (int i = 0; i < 20; i++)
         drive($sformatf("sat%0d", i), 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0,
               1'b0, 1'b0, 1'b0, 1'b0, IHM, (i < 15) ? i : 15);
      norm("sat_hold", NRM, 15);
      drive("sat_mb", 1'b1, 1'b1, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, ZER, 15);
      drive("sat_mb2", 1'b1, 1'b1, 1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, NRM, 15);
      for (int i = 0; i < 10 && q.size() != 0; i++)
         @(negedge CLK);
      #4;
      if (q.size() != 0) begin
         tests++;
         fails++;
         $display("FAIL drain: %0d expectations left, required 0", q.size());
      end
      done = 1'b1;
   end
   initial begin
      fork
         wait (done);
         #20000;
      join_any
      if (!done) begin
         tests++;
         fails++;
         $display("FAIL timeout: done=0 required 1");
      end
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
